// File: rtl/write_master_queued.sv
// Queued write master: request FIFO, independently issued AW/W channels,
// bounded outstanding-B tracking and registered in-order response return.
// Optional per-entry byte strobes: define WRITE_MASTER_QUEUED_WSTRB_EN.
module write_master_queued #(
    parameter int ADDR_WDTH       = 4,
    parameter int DATA_WDTH       = 32,
    parameter int RESP_WDTH       = 2,
    parameter int DEPTH_LOG2      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ERR_CNT_WDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WDTH-1:0]    req_addr,
    input  logic [DATA_WDTH-1:0]    req_data,
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
    input  logic [DATA_WDTH/8-1:0]  req_strb,
    output logic [DATA_WDTH/8-1:0]  w_strb,
`endif
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ADDR_WDTH-1:0]    aw_address,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_WDTH-1:0]    w_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [RESP_WDTH-1:0]    b_resp,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [RESP_WDTH-1:0]    rsp_resp,
    output logic [ERR_CNT_WDTH-1:0] err_cnt,
    output logic                    idle,
    output logic                    proto_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [OW-1:0] MAX_OS  = OW'(MAX_OUTSTANDING);

    logic [ADDR_WDTH-1:0]   addr_mem [DEPTH];
    logic [DATA_WDTH-1:0]   data_mem [DEPTH];
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
    logic [DATA_WDTH/8-1:0] strb_mem [DEPTH];
`endif

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         aw_ptr;
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         pend_aw;
    logic [PW-1:0]         pend_w;
    logic [PW-1:0]         occupancy;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] aw_idx;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [OW-1:0]         outstanding;

    logic push;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic b_dec;

    // Entry lives until both channels have consumed it, so the lagging pointer sets occupancy.
    assign pend_aw   = wr_ptr - aw_ptr;
    assign pend_w    = wr_ptr - w_ptr;
    assign occupancy = (pend_aw > pend_w) ? pend_aw : pend_w;

    assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
    assign aw_idx = aw_ptr[DEPTH_LOG2-1:0];
    assign w_idx  = w_ptr[DEPTH_LOG2-1:0];

    assign req_ready  = (occupancy < DEPTH_P);
    assign aw_valid   = (pend_aw != '0) && (outstanding < MAX_OS);
    assign w_valid    = (pend_w != '0);
    assign aw_address = addr_mem[aw_idx];
    assign w_data     = data_mem[w_idx];
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
    assign w_strb     = strb_mem[w_idx];
`endif
    assign b_ready    = ~rsp_valid | rsp_ready;
    assign idle       = (occupancy == '0) && (outstanding == '0) && ~rsp_valid;

    assign push    = req_valid & req_ready;
    assign aw_fire = aw_valid & aw_ready;
    assign w_fire  = w_valid & w_ready;
    assign b_fire  = b_valid & b_ready;
    assign b_dec   = b_fire & (outstanding != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= req_addr;
            data_mem[wr_idx] <= req_data;
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
            strb_mem[wr_idx] <= req_strb;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            aw_ptr <= '0;
            w_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (aw_fire) begin
                aw_ptr <= aw_ptr + PW'(1);
            end
            if (w_fire) begin
                w_ptr <= w_ptr + PW'(1);
            end
        end
    end

    // A B with nothing outstanding is not counted down, so the count cannot underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({aw_fire, b_dec})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_resp  <= '0;
        end else if (b_fire) begin
            rsp_valid <= 1'b1;
            rsp_resp  <= b_resp;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (b_fire && (b_resp != '0) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_WDTH'(1);
            end
            if (b_fire && (outstanding == '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_master_queued.sv
// Randomized self-checking bench for write_master_queued against a
// transaction-count reference model (FIFO contents kept as queues).
module tb_write_master_queued;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int RW    = 2;
    localparam int DL    = 2;
    localparam int MO    = 4;
    localparam int EW    = 8;
    localparam int DEPTH = 2 ** DL;
    localparam int EMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
    logic [DW/8-1:0] req_strb = '0;
    logic [DW/8-1:0] w_strb;
`endif
    logic          aw_valid;
    logic          aw_ready = 1'b0;
    logic [AW-1:0] aw_address;
    logic          w_valid;
    logic          w_ready = 1'b0;
    logic [DW-1:0] w_data;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [RW-1:0] b_resp = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [RW-1:0] rsp_resp;
    logic [EW-1:0] err_cnt;
    logic          idle;
    logic          proto_err;

    always #5 clk = ~clk;

    write_master_queued #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW),
        .DEPTH_LOG2(DL), .MAX_OUTSTANDING(MO), .ERR_CNT_WDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
        .req_strb(req_strb), .w_strb(w_strb),
`endif
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .err_cnt(err_cnt), .idle(idle), .proto_err(proto_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts of pushes and channel handshakes plus stored requests.
    int            pushed, aw_done, w_done, outs, err_m, b_count;
    bit            rsp_v_m, proto_m, last_push, last_bf;
    logic [RW-1:0] rsp_r_m;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
    logic [DW/8-1:0] strb_q[$];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        return (pushed == aw_done) && (pushed == w_done) && (outs == 0) && !rsp_v_m;
    endfunction

    task automatic model_reset();
        pushed = 0; aw_done = 0; w_done = 0; outs = 0; err_m = 0;
        rsp_v_m = 0; rsp_r_m = '0; proto_m = 0;
        addr_q.delete(); data_q.delete();
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
        strb_q.delete();
`endif
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int            pa, pw, occ;
        bit            rr, awv, wv, br, idl, push, awf, wf, bf, dec, rsp_rdy;
        logic [AW-1:0] a_s;
        logic [DW-1:0] d_s;
        logic [RW-1:0] r_s;
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
        logic [DW/8-1:0] s_s;
        s_s = req_strb;
`endif
        #1;
        pa  = pushed - aw_done;
        pw  = pushed - w_done;
        occ = (pa > pw) ? pa : pw;
        rr  = occ < DEPTH;
        awv = (pa > 0) && (outs < MO);
        wv  = pw > 0;
        br  = !rsp_v_m || rsp_ready;
        idl = (occ == 0) && (outs == 0) && !rsp_v_m;
        check("req_ready", 32'(req_ready), 32'(rr));
        check("aw_valid", 32'(aw_valid), 32'(awv));
        check("w_valid", 32'(w_valid), 32'(wv));
        check("b_ready", 32'(b_ready), 32'(br));
        check("rsp_valid", 32'(rsp_valid), 32'(rsp_v_m));
        check("idle", 32'(idle), 32'(idl));
        check("err_cnt", 32'(err_cnt), 32'(err_m));
        check("proto_err", 32'(proto_err), 32'(proto_m));
        if (awv) check("aw_address", 32'(aw_address), 32'(addr_q[aw_done]));
        if (wv) check("w_data", w_data, data_q[w_done]);
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
        if (wv) check("w_strb", 32'(w_strb), 32'(strb_q[w_done]));
`endif
        if (rsp_v_m) check("rsp_resp", 32'(rsp_resp), 32'(rsp_r_m));
        push = req_valid && rr;
        awf  = awv && aw_ready;
        wf   = wv && w_ready;
        bf   = b_valid && br;
        a_s = req_addr; d_s = req_data; r_s = b_resp; rsp_rdy = rsp_ready;
        @(posedge clk);
        if (push) begin
            addr_q.push_back(a_s);
            data_q.push_back(d_s);
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
            strb_q.push_back(s_s);
`endif
            pushed++;
        end
        if (awf) aw_done++;
        if (wf) w_done++;
        dec = bf && (outs > 0);
        if (bf && outs == 0) proto_m = 1;
        outs = outs + (awf ? 1 : 0) - (dec ? 1 : 0);
        if (bf) begin
            b_count++;
            if (r_s != 0 && err_m < EMAX) err_m++;
            rsp_v_m = 1;
            rsp_r_m = r_s;
        end else if (rsp_rdy) begin
            rsp_v_m = 0;
        end
        last_push = push;
        last_bf   = bf;
        @(negedge clk);
    endtask

    task automatic new_req();
        req_addr = AW'($urandom);
        req_data = $urandom;
`ifdef WRITE_MASTER_QUEUED_WSTRB_EN
        req_strb = (DW/8)'($urandom);
`endif
    endtask

    task automatic drive_rand(input int p_req, input int p_aw, input int p_w,
                              input int p_b, input int p_err);
        req_valid = ($urandom_range(99) < p_req);
        new_req();
        aw_ready  = ($urandom_range(99) < p_aw);
        w_ready   = ($urandom_range(99) < p_w);
        b_valid   = (outs > 0) && ($urandom_range(99) < p_b);
        b_resp    = ($urandom_range(99) < p_err) ? RW'($urandom_range(3, 1)) : '0;
        rsp_ready = ($urandom_range(99) < 70);
    endtask

    // Holds each request stable until the model says it was accepted.
    task automatic push_n(input int n);
        int idx = 0;
        int k = 0;
        new_req();
        while (idx < n && k < 60) begin
            req_valid = 1'b1;
            cycle();
            if (last_push) begin
                idx++;
                new_req();
            end
            k++;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (!model_idle() && k < 200) begin
            req_valid = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
            b_valid = (outs > 0); b_resp = '0; rsp_ready = 1'b1;
            cycle();
            k++;
        end
        b_valid = 1'b0;
        check("drain_idle", 32'(idle), 32'd1);
    endtask

    task automatic send_b(input logic [RW-1:0] r);
        int k = 0;
        req_valid = 1'b0; b_valid = 1'b1; b_resp = r;
        do begin
            rsp_ready = ($urandom_range(2) == 0);
            cycle();
            k++;
        end while (!last_bf && k < 50);
        b_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_aw_valid", 32'(aw_valid), 32'd0);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        model_reset();
        req_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_resp = '0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int b0;
        b_count = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 4'd3; req_data = 32'hDEADBEEF;
        cycle();
        req_valid = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
        cycle();
        cycle();
        b_valid = 1'b1; b_resp = '0;
        cycle();
        b_valid = 1'b0;
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_resp", 32'(rsp_resp), 32'd0);
        cycle();
        check("single_idle", 32'(idle), 32'd1);

        // Fill: 4 accepted, 5th held until a retire
        aw_ready = 1'b0; w_ready = 1'b0;
        new_req();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            cycle();
            if (last_push) new_req();
        end
        check("fill_full", 32'(req_ready), 32'd0);
        aw_ready = 1'b1; w_ready = 1'b1;
        cycle();
        aw_ready = 1'b0; w_ready = 1'b0;
        check("fill_reopen", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
        drain();

        // Outstanding limit
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0; rsp_ready = 1'b1;
        push_n(6);
        for (int i = 0; i < 4; i++) cycle();
        check("os_limit_awv", 32'(aw_valid), 32'd0);
        check("os_w_drained", 32'(w_valid), 32'd0);
        b_valid = 1'b1; b_resp = '0;
        cycle();
        b_valid = 1'b0;
        check("os_reenable", 32'(aw_valid), 32'd1);
        drain();

        // Skewed channels: W ahead of AW
        aw_ready = 1'b0; w_ready = 1'b1;
        push_n(3);
        for (int i = 0; i < 3; i++) cycle();
        check("skew_w_done", 32'(w_valid), 32'd0);
        check("skew_aw_pend", 32'(aw_valid), 32'd1);
        check("skew_not_idle", 32'(idle), 32'd0);
        aw_ready = 1'b1;
        drain();

        // Error responses with backpressure
        aw_ready = 1'b1; w_ready = 1'b1; rsp_ready = 1'b1;
        push_n(3);
        cycle();
        cycle();
        send_b(2'd2);
        send_b(2'd0);
        send_b(2'd3);
        drain();
        check("err_mix", 32'(err_cnt), 32'd2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive_rand(60, 60, 60, 50, 30);
            cycle();
        end
        drain();

        // Saturation with at least 300 error responses
        b0 = b_count;
        k = 0;
        while (b_count - b0 < 300 && k < 3000) begin
            drive_rand(80, 100, 100, 90, 100);
            rsp_ready = 1'b1;
            cycle();
            k++;
        end
        drain();
        check("err_sat", 32'(err_cnt), 32'd255);

        // Protocol error while idle
        b_valid = 1'b1; b_resp = '0; rsp_ready = 1'b1;
        cycle();
        b_valid = 1'b0;
        cycle();
        check("proto_set", 32'(proto_err), 32'd1);

        // Reset mid-burst, then a stray B after reset
        for (int i = 0; i < 20; i++) begin
            drive_rand(80, 50, 50, 50, 30);
            cycle();
        end
        do_reset();
        b_valid = 1'b1; b_resp = 2'd1; rsp_ready = 1'b1;
        cycle();
        b_valid = 1'b0;
        check("proto_after_rst", 32'(proto_err), 32'd1);
        check("err_after_rst", 32'(err_cnt), 32'd1);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            drive_rand(70, 70, 70, 60, 40);
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
